// File: rtl/alu_exec_unit.sv
// rtl/alu_exec_unit.sv - MIPS execute stage: ALU-control decode, ALU and branch-target adder, registered outputs
// Optional ALU_OVERFLOW_EN adds a registered signed-overflow flag for ADD/SUB.
module alu_exec_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [2:0]       alu_op,
  input  logic             alu_src,
  input  logic [WIDTH-1:0] pc_plus4,
  input  logic [WIDTH-1:0] rs_data,
  input  logic [WIDTH-1:0] rt_data,
  input  logic [WIDTH-1:0] imm_ext,
  input  logic [4:0]       shamt,
  output logic             out_valid,
  output logic [WIDTH-1:0] alu_result,
  output logic             zero,
  output logic [WIDTH-1:0] branch_target,
  output logic [3:0]       alu_ctrl
`ifdef ALU_OVERFLOW_EN
  ,
  output logic             overflow
`endif
);

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SLL  = 4'b0011;
  localparam logic [3:0] OP_SRL  = 4'b0100;
  localparam logic [3:0] OP_XOR  = 4'b0101;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_SLTU = 4'b1000;
  localparam logic [3:0] OP_SRA  = 4'b1001;
  localparam logic [3:0] OP_LUI  = 4'b1010;
  localparam logic [3:0] OP_NOR  = 4'b1100;
  localparam logic [3:0] OP_INV  = 4'b1111;

  logic [5:0]       funct;
  logic [3:0]       ctrl;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] target;
  logic             slt_bit;
  logic             sltu_bit;

  assign funct = imm_ext[5:0];

  always_comb begin
    ctrl = OP_INV;
    case (alu_op)
      3'b000: ctrl = OP_ADD;
      3'b001: ctrl = OP_SUB;
      3'b010: begin
        case (funct)
          6'b100000, 6'b100001: ctrl = OP_ADD;
          6'b100010, 6'b100011: ctrl = OP_SUB;
          6'b100100:            ctrl = OP_AND;
          6'b100101:            ctrl = OP_OR;
          6'b100110:            ctrl = OP_XOR;
          6'b100111:            ctrl = OP_NOR;
          6'b101010:            ctrl = OP_SLT;
          6'b101011:            ctrl = OP_SLTU;
          6'b000000:            ctrl = OP_SLL;
          6'b000010:            ctrl = OP_SRL;
          6'b000011:            ctrl = OP_SRA;
          default:              ctrl = OP_INV;
        endcase
      end
      3'b011: ctrl = OP_AND;
      3'b100: ctrl = OP_OR;
      3'b101: ctrl = OP_SLT;
      3'b110: ctrl = OP_LUI;
      3'b111: ctrl = OP_XOR;
      default: ctrl = OP_INV;
    endcase
  end

  assign op_a     = rs_data;
  assign op_b     = alu_src ? imm_ext : rt_data;
  assign sum      = op_a + op_b;
  assign diff     = op_a - op_b;
  assign slt_bit  = $signed(op_a) < $signed(op_b);
  assign sltu_bit = op_a < op_b;
  assign target   = pc_plus4 + (imm_ext << 2);

  // Shifts and LUI operate on B only; A is ignored for them.
  always_comb begin
    result = '0;
    case (ctrl)
      OP_AND:  result = op_a & op_b;
      OP_OR:   result = op_a | op_b;
      OP_ADD:  result = sum;
      OP_SUB:  result = diff;
      OP_XOR:  result = op_a ^ op_b;
      OP_NOR:  result = ~(op_a | op_b);
      OP_SLT:  result = {{(WIDTH-1){1'b0}}, slt_bit};
      OP_SLTU: result = {{(WIDTH-1){1'b0}}, sltu_bit};
      OP_SLL:  result = op_b << shamt;
      OP_SRL:  result = op_b >> shamt;
      OP_SRA:  result = WIDTH'($signed(op_b) >>> shamt);
      OP_LUI:  result = op_b << 16;
      default: result = '0;
    endcase
  end

`ifdef ALU_OVERFLOW_EN
  logic ovf;

  always_comb begin
    ovf = 1'b0;
    case (ctrl)
      OP_ADD: ovf = (op_a[WIDTH-1] == op_b[WIDTH-1]) && (sum[WIDTH-1] != op_a[WIDTH-1]);
      OP_SUB: ovf = (op_a[WIDTH-1] != op_b[WIDTH-1]) && (diff[WIDTH-1] != op_a[WIDTH-1]);
      default: ovf = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      overflow <= 1'b0;
    end else if (in_valid) begin
      overflow <= ovf;
    end
  end
`endif

  // Data outputs hold across idle cycles; only out_valid drops.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid     <= 1'b0;
      alu_result    <= '0;
      zero          <= 1'b0;
      branch_target <= '0;
      alu_ctrl      <= 4'b0000;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        alu_result    <= result;
        zero          <= (result == '0);
        branch_target <= target;
        alu_ctrl      <= ctrl;
      end
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// tb/tb_alu_exec_unit.sv - directed self-checking bench for alu_exec_unit
module tb_alu_exec_unit;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [2:0]  alu_op;
  logic        alu_src;
  logic [31:0] pc_plus4;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic [31:0] imm_ext;
  logic [4:0]  shamt;
  logic        out_valid;
  logic [31:0] alu_result;
  logic        zero;
  logic [31:0] branch_target;
  logic [3:0]  alu_ctrl;
`ifdef ALU_OVERFLOW_EN
  logic        overflow;
`endif

  int tests_run;
  int tests_failed;

  alu_exec_unit #(.WIDTH(32)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .alu_op(alu_op),
    .alu_src(alu_src),
    .pc_plus4(pc_plus4),
    .rs_data(rs_data),
    .rt_data(rt_data),
    .imm_ext(imm_ext),
    .shamt(shamt),
    .out_valid(out_valid),
    .alu_result(alu_result),
    .zero(zero),
    .branch_target(branch_target),
    .alu_ctrl(alu_ctrl)
`ifdef ALU_OVERFLOW_EN
    ,
    .overflow(overflow)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input logic v, input logic [2:0] op, input logic src,
                       input logic [31:0] pc, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] imm, input logic [4:0] sh);
    in_valid = v;
    alu_op   = op;
    alu_src  = src;
    pc_plus4 = pc;
    rs_data  = a;
    rt_data  = b;
    imm_ext  = imm;
    shamt    = sh;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    drive(1'b1, 3'b000, 1'b0, 32'h100, 32'd3, 32'd4, 32'h20, 5'd0);
    drive(1'b1, 3'b000, 1'b0, 32'h100, 32'd3, 32'd4, 32'h20, 5'd0);
    tests_run++;
    if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    tests_run++;
    if (alu_result !== 32'h0) begin tests_failed++; $display("FAIL reset_result: got %h expected 0", alu_result); end
    tests_run++;
    if (zero !== 1'b0 || alu_ctrl !== 4'b0000) begin tests_failed++; $display("FAIL reset_zero_ctrl: got %b/%b expected 0/0000", zero, alu_ctrl); end
    tests_run++;
    if (branch_target !== 32'h0) begin tests_failed++; $display("FAIL reset_branch: got %h expected 0", branch_target); end
`ifdef ALU_OVERFLOW_EN
    tests_run++;
    if (overflow !== 1'b0) begin tests_failed++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
`endif
    rst_n = 1'b1;
    drive(1'b1, 3'b000, 1'b0, 32'h0, 32'd9, 32'd1, 32'h0, 5'd0);
    tests_run++;
    if (out_valid !== 1'b1 || alu_result !== 32'd10) begin tests_failed++; $display("FAIL reset_release: got v=%b r=%h expected v=1 r=0000000a", out_valid, alu_result); end
  endtask

  task automatic test_add_sub;
    drive(1'b1, 3'b010, 1'b0, 32'h0, 32'd7, 32'd5, 32'h20, 5'd0);
    tests_run++;
    if (alu_result !== 32'd12 || zero !== 1'b0 || alu_ctrl !== 4'b0010) begin tests_failed++; $display("FAIL rtype_add: got r=%h z=%b c=%b expected r=0000000c z=0 c=0010", alu_result, zero, alu_ctrl); end
    drive(1'b1, 3'b010, 1'b0, 32'h0, 32'd5, 32'd5, 32'h22, 5'd0);
    tests_run++;
    if (alu_result !== 32'd0 || zero !== 1'b1 || alu_ctrl !== 4'b0110) begin tests_failed++; $display("FAIL rtype_sub: got r=%h z=%b c=%b expected r=0 z=1 c=0110", alu_result, zero, alu_ctrl); end
    drive(1'b1, 3'b010, 1'b0, 32'h0, 32'd3, 32'd5, 32'h23, 5'd0);
    tests_run++;
    if (alu_result !== 32'hFFFFFFFE) begin tests_failed++; $display("FAIL subu_wrap: got %h expected fffffffe", alu_result); end
    drive(1'b1, 3'b010, 1'b0, 32'h0, 32'hF0F0_0000, 32'h0F0F_00FF, 32'h27, 5'd0);
    tests_run++;
    if (alu_result !== 32'h0000_FF00 || alu_ctrl !== 4'b1100) begin tests_failed++; $display("FAIL rtype_nor: got r=%h c=%b expected r=0000ff00 c=1100", alu_result, alu_ctrl); end
  endtask

  task automatic test_slt;
    drive(1'b1, 3'b010, 1'b0, 32'h0, 32'hFFFFFFFF, 32'd1, 32'h2A, 5'd0);
    tests_run++;
    if (alu_result !== 32'd1 || alu_ctrl !== 4'b0111) begin tests_failed++; $display("FAIL slt: got r=%h c=%b expected r=1 c=0111", alu_result, alu_ctrl); end
    drive(1'b1, 3'b010, 1'b0, 32'h0, 32'hFFFFFFFF, 32'd1, 32'h2B, 5'd0);
    tests_run++;
    if (alu_result !== 32'd0 || zero !== 1'b1 || alu_ctrl !== 4'b1000) begin tests_failed++; $display("FAIL sltu: got r=%h z=%b c=%b expected r=0 z=1 c=1000", alu_result, zero, alu_ctrl); end
    drive(1'b1, 3'b101, 1'b1, 32'h0, 32'hFFFFFFF0, 32'd0, 32'hFFFFFFF8, 5'd0);
    tests_run++;
    if (alu_result !== 32'd1) begin tests_failed++; $display("FAIL slti: got %h expected 1", alu_result); end
  endtask

  task automatic test_shifts;
    drive(1'b1, 3'b010, 1'b0, 32'h0, 32'hDEADBEEF, 32'h80000010, 32'h00, 5'd4);
    tests_run++;
    if (alu_result !== 32'h00000100 || alu_ctrl !== 4'b0011) begin tests_failed++; $display("FAIL sll: got r=%h c=%b expected r=00000100 c=0011", alu_result, alu_ctrl); end
    drive(1'b1, 3'b010, 1'b0, 32'h0, 32'hDEADBEEF, 32'h80000010, 32'h02, 5'd4);
    tests_run++;
    if (alu_result !== 32'h08000001 || alu_ctrl !== 4'b0100) begin tests_failed++; $display("FAIL srl: got r=%h c=%b expected r=08000001 c=0100", alu_result, alu_ctrl); end
    drive(1'b1, 3'b010, 1'b0, 32'h0, 32'hDEADBEEF, 32'h80000010, 32'h03, 5'd4);
    tests_run++;
    if (alu_result !== 32'hF8000001 || alu_ctrl !== 4'b1001) begin tests_failed++; $display("FAIL sra: got r=%h c=%b expected r=f8000001 c=1001", alu_result, alu_ctrl); end
    drive(1'b1, 3'b010, 1'b0, 32'h0, 32'h0, 32'h00000001, 32'h00, 5'd31);
    tests_run++;
    if (alu_result !== 32'h80000000) begin tests_failed++; $display("FAIL sll31: got %h expected 80000000", alu_result); end
  endtask

  task automatic test_imm_branch;
    drive(1'b1, 3'b000, 1'b1, 32'h0, 32'h1000, 32'h5555, 32'hFFFFFFFC, 5'd0);
    tests_run++;
    if (alu_result !== 32'h00000FFC) begin tests_failed++; $display("FAIL addi: got %h expected 00000ffc", alu_result); end
    drive(1'b1, 3'b001, 1'b0, 32'h40, 32'd1, 32'd2, 32'hFFFFFFFE, 5'd0);
    tests_run++;
    if (branch_target !== 32'h38) begin tests_failed++; $display("FAIL branch_back: got %h expected 00000038", branch_target); end
    drive(1'b1, 3'b110, 1'b1, 32'hFFFFFFF0, 32'hFFFF, 32'h0, 32'h1234, 5'd0);
    tests_run++;
    if (alu_result !== 32'h12340000 || alu_ctrl !== 4'b1010) begin tests_failed++; $display("FAIL lui: got r=%h c=%b expected r=12340000 c=1010", alu_result, alu_ctrl); end
    tests_run++;
    if (branch_target !== 32'h000048C0) begin tests_failed++; $display("FAIL branch_wrap: got %h expected 000048c0", branch_target); end
  endtask

  task automatic test_logic_ops;
    drive(1'b1, 3'b011, 1'b1, 32'h0, 32'hFF00FF00, 32'h0, 32'h0F0F0F0F, 5'd0);
    tests_run++;
    if (alu_result !== 32'h0F000F00) begin tests_failed++; $display("FAIL andi: got %h expected 0f000f00", alu_result); end
    drive(1'b1, 3'b100, 1'b1, 32'h0, 32'hFF00FF00, 32'h0, 32'h0F0F0F0F, 5'd0);
    tests_run++;
    if (alu_result !== 32'hFF0FFF0F) begin tests_failed++; $display("FAIL ori: got %h expected ff0fff0f", alu_result); end
    drive(1'b1, 3'b111, 1'b1, 32'h0, 32'hFF00FF00, 32'h0, 32'h0F0F0F0F, 5'd0);
    tests_run++;
    if (alu_result !== 32'hF00FF00F || alu_ctrl !== 4'b0101) begin tests_failed++; $display("FAIL xori: got r=%h c=%b expected r=f00ff00f c=0101", alu_result, alu_ctrl); end
  endtask

  task automatic test_invalid_hold;
    drive(1'b1, 3'b010, 1'b0, 32'h0, 32'd7, 32'd9, 32'h3F, 5'd0);
    tests_run++;
    if (alu_result !== 32'd0 || zero !== 1'b1 || alu_ctrl !== 4'b1111) begin tests_failed++; $display("FAIL invalid_funct: got r=%h z=%b c=%b expected r=0 z=1 c=1111", alu_result, zero, alu_ctrl); end
`ifdef ALU_OVERFLOW_EN
    drive(1'b1, 3'b000, 1'b0, 32'h0, 32'h7FFFFFFF, 32'd1, 32'h0, 5'd0);
    tests_run++;
    if (alu_result !== 32'h80000000 || overflow !== 1'b1) begin tests_failed++; $display("FAIL add_overflow: got r=%h o=%b expected r=80000000 o=1", alu_result, overflow); end
    drive(1'b1, 3'b001, 1'b0, 32'h0, 32'h80000000, 32'd1, 32'h0, 5'd0);
    tests_run++;
    if (alu_result !== 32'h7FFFFFFF || overflow !== 1'b1) begin tests_failed++; $display("FAIL sub_overflow: got r=%h o=%b expected r=7fffffff o=1", alu_result, overflow); end
    drive(1'b1, 3'b100, 1'b0, 32'h0, 32'h7FFFFFFF, 32'd1, 32'h0, 5'd0);
    tests_run++;
    if (overflow !== 1'b0) begin tests_failed++; $display("FAIL or_no_overflow: got %b expected 0", overflow); end
`endif
    drive(1'b1, 3'b000, 1'b0, 32'h200, 32'd100, 32'd23, 32'h4, 5'd0);
    drive(1'b0, 3'b001, 1'b0, 32'h900, 32'd1, 32'd1, 32'h8, 5'd0);
    tests_run++;
    if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL idle_valid: got %b expected 0", out_valid); end
    tests_run++;
    if (alu_result !== 32'd123 || zero !== 1'b0 || alu_ctrl !== 4'b0010 || branch_target !== 32'h210) begin tests_failed++; $display("FAIL idle_hold: got r=%h z=%b c=%b t=%h expected r=0000007b z=0 c=0010 t=00000210", alu_result, zero, alu_ctrl, branch_target); end
  endtask

  task automatic test_back_to_back;
    drive(1'b1, 3'b000, 1'b0, 32'h0, 32'd1, 32'd2, 32'h0, 5'd0);
    tests_run++;
    if (alu_result !== 32'd3 || out_valid !== 1'b1) begin tests_failed++; $display("FAIL b2b_0: got r=%h v=%b expected r=3 v=1", alu_result, out_valid); end
    drive(1'b1, 3'b001, 1'b0, 32'h0, 32'd10, 32'd4, 32'h0, 5'd0);
    tests_run++;
    if (alu_result !== 32'd6 || out_valid !== 1'b1) begin tests_failed++; $display("FAIL b2b_1: got r=%h v=%b expected r=6 v=1", alu_result, out_valid); end
    rst_n = 1'b0;
    drive(1'b1, 3'b000, 1'b0, 32'h0, 32'd50, 32'd50, 32'h0, 5'd0);
    tests_run++;
    if (alu_result !== 32'd0 || out_valid !== 1'b0) begin tests_failed++; $display("FAIL midreset_drop: got r=%h v=%b expected r=0 v=0", alu_result, out_valid); end
    rst_n = 1'b1;
    drive(1'b1, 3'b000, 1'b0, 32'h0, 32'd20, 32'd22, 32'h0, 5'd0);
    tests_run++;
    if (alu_result !== 32'd42 || out_valid !== 1'b1) begin tests_failed++; $display("FAIL midreset_resume: got r=%h v=%b expected r=0000002a v=1", alu_result, out_valid); end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    alu_op   = 3'b000;
    alu_src  = 1'b0;
    pc_plus4 = '0;
    rs_data  = '0;
    rt_data  = '0;
    imm_ext  = '0;
    shamt    = '0;
    test_reset;
    test_add_sub;
    test_slt;
    test_shifts;
    test_imm_branch;
    test_logic_ops;
    test_invalid_hold;
    test_back_to_back;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
